// File: rtl/pong_pkg.sv
// Shared Pong types: FSM state encoding, overlay codes, VGA timing.
// Also holds the two-digit BCD increment used by the score counter.
package pong_pkg;

    localparam int HD = 640;
    localparam int VD = 480;
    localparam int HT = 800;
    localparam int VT = 525;

    typedef enum logic [1:0] {
        NEWGAME = 2'd0,
        PLAY    = 2'd1,
        NEWBALL = 2'd2,
        OVER    = 2'd3
    } state_t;

    localparam logic [1:0] TXT_SCORE = 2'b00;
    localparam logic [1:0] TXT_RULES = 2'b01;
    localparam logic [1:0] TXT_OVER  = 2'b10;

    // {tens, ones} BCD increment, 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        logic [3:0] d1;
        logic [3:0] d0;
        d1 = s[7:4];
        d0 = s[3:0];
        if (d0 == 4'd9) begin
            d0 = 4'd0;
            d1 = (d1 == 4'd9) ? 4'd0 : d1 + 4'd1;
        end else begin
            d0 = d0 + 4'd1;
        end
        return {d1, d0};
    endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Once-per-frame refresh tick plus a loadable frame-counted delay.
// In: clk, reset(n), p_tick, pixel_x/y, timer_start. Out: refr_tick, timer_up.
module pong_frame_timer
    import pong_pkg::*;
#(
    parameter int REFR_LINE    = 480,
    parameter int TIMER_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       timer_start,
    output logic       refr_tick,
    output logic       timer_up
);

    localparam logic [7:0] LOAD = 8'(TIMER_FRAMES);

    logic [7:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refr_tick <= 1'b0;
            count     <= 8'd0;
        end else begin
            refr_tick <= p_tick && (pixel_x == 10'd0)
                         && (pixel_y == 10'(REFR_LINE));
            // A load in the same cycle as a tick wins over the decrement.
            if (timer_start)
                count <= LOAD;
            else if (refr_tick && (count != 8'd0))
                count <= count - 8'd1;
        end
    end

    assign timer_up = (count == 8'd0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: state FSM, BCD score, balls, overlay select.
// In: clk, reset(n), p_tick, pixel_x/y, btn, hit, miss. Out: refr_tick,
// gra_still, text_sel, score_d1/d0, balls_left.
module pong_game_ctrl #(
    parameter int VD           = 480,
    parameter int TIMER_FRAMES = 120,
    parameter int NUM_BALLS    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic [1:0] btn,
    input  logic       hit,
    input  logic       miss,
    output logic       refr_tick,
    output logic       gra_still,
    output logic [1:0] text_sel,
    output logic [3:0] score_d1,
    output logic [3:0] score_d0,
    output logic [1:0] balls_left
);
    import pong_pkg::*;

    state_t state, state_nx;
    logic   timer_start;
    logic   timer_up;
    logic   score_clr;
    logic   score_inc;
    logic   balls_load;
    logic   balls_dec;

    pong_frame_timer #(
        .REFR_LINE   (VD),
        .TIMER_FRAMES(TIMER_FRAMES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .p_tick     (p_tick),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .timer_start(timer_start),
        .refr_tick  (refr_tick),
        .timer_up   (timer_up)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= NEWGAME;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        timer_start = 1'b0;
        score_clr   = 1'b0;
        score_inc   = 1'b0;
        balls_load  = 1'b0;
        balls_dec   = 1'b0;
        unique case (state)
            NEWGAME: begin
                if (btn != 2'b00) begin
                    score_clr  = 1'b1;
                    balls_load = 1'b1;
                    state_nx   = PLAY;
                end
            end
            PLAY: begin
                score_inc = hit;
                if (miss) begin
                    timer_start = 1'b1;
                    balls_dec   = 1'b1;
                    state_nx    = (balls_left <= 2'd1) ? OVER : NEWBALL;
                end
            end
            NEWBALL: begin
                if (timer_up && (btn != 2'b00))
                    state_nx = PLAY;
            end
            OVER: begin
                if (timer_up)
                    state_nx = NEWGAME;
            end
            default: state_nx = NEWGAME;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            score_d1 <= 4'd0;
            score_d0 <= 4'd0;
        end else if (score_clr) begin
            score_d1 <= 4'd0;
            score_d0 <= 4'd0;
        end else if (score_inc) begin
            {score_d1, score_d0} <= bcd_inc({score_d1, score_d0});
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            balls_left <= 2'd0;
        else if (balls_load)
            balls_left <= 2'(NUM_BALLS);
        else if (balls_dec && (balls_left != 2'd0))
            balls_left <= balls_left - 2'd1;
    end

    // Moore outputs straight from state, so an async reset shows at once.
    always_comb begin
        gra_still = 1'b1;
        text_sel  = TXT_RULES;
        unique case (state)
            NEWGAME: text_sel = TXT_RULES;
            PLAY: begin
                gra_still = 1'b0;
                text_sel  = TXT_SCORE;
            end
            NEWBALL: text_sel = TXT_SCORE;
            OVER:    text_sel = TXT_OVER;
            default: text_sel = TXT_RULES;
        endcase
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: vectors, scripted game
// sequences and random play against an integer-level game model.
module tb_pong_game_ctrl;

    localparam int TF  = 120;
    localparam int NB  = 3;
    localparam int VDL = 480;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       p_tick = 1'b0;
    logic [9:0] pixel_x = '0;
    logic [9:0] pixel_y = '0;
    logic [1:0] btn = '0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       refr_tick;
    logic       gra_still;
    logic [1:0] text_sel;
    logic [3:0] score_d1;
    logic [3:0] score_d0;
    logic [1:0] balls_left;

    pong_game_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .p_tick    (p_tick),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .btn       (btn),
        .hit       (hit),
        .miss      (miss),
        .refr_tick (refr_tick),
        .gra_still (gra_still),
        .text_sel  (text_sel),
        .score_d1  (score_d1),
        .score_d0  (score_d0),
        .balls_left(balls_left)
    );

    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef enum int {M_NEWGAME, M_PLAY, M_NEWBALL, M_OVER} mmode_t;
    mmode_t m_mode;
    int     m_score;
    int     m_balls;
    int     m_frames;
    bit     m_refr;

    typedef struct {
        bit pt;
        int px;
        int py;
        bit exp_refr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_NEWGAME;
        m_score  = 0;
        m_balls  = 0;
        m_frames = 0;
        m_refr   = 1'b0;
    endtask

    // Game rules applied once per clock with the inputs of that clock.
    task automatic model_step();
        bit delay_over;
        bit start;
        delay_over = (m_frames == 0);
        start = 1'b0;
        case (m_mode)
            M_NEWGAME:
                if (btn != 0) begin
                    m_score = 0;
                    m_balls = NB;
                    m_mode  = M_PLAY;
                end
            M_PLAY: begin
                if (hit) m_score = (m_score + 1) % 100;
                if (miss) begin
                    start = 1'b1;
                    if (m_balls <= 1) begin
                        m_balls = 0;
                        m_mode  = M_OVER;
                    end else begin
                        m_balls = m_balls - 1;
                        m_mode  = M_NEWBALL;
                    end
                end
            end
            M_NEWBALL: if (delay_over && btn != 0) m_mode = M_PLAY;
            M_OVER:    if (delay_over) m_mode = M_NEWGAME;
        endcase
        if (start) m_frames = TF;
        else if (m_refr && m_frames > 0) m_frames = m_frames - 1;
        m_refr = p_tick && pixel_x == 0 && pixel_y == VDL;
    endtask

    task automatic check_model(input string name);
        logic [13:0] exp;
        logic [13:0] act;
        logic [1:0]  txt;
        txt = (m_mode == M_OVER) ? 2'b10 :
              (m_mode == M_NEWGAME) ? 2'b01 : 2'b00;
        exp = {m_refr, m_mode != M_PLAY, txt, 4'(m_score / 10),
               4'(m_score % 10), 2'(m_balls)};
        act = {refr_tick, gra_still, text_sel, score_d1, score_d0,
               balls_left};
        check(name, {18'd0, act}, {18'd0, exp});
    endtask

    task automatic step(input logic [1:0] b, input logic h, input logic m,
                        input logic pt, input int px, input int py);
        btn     = b;
        hit     = h;
        miss    = m;
        p_tick  = pt;
        pixel_x = 10'(px);
        pixel_y = 10'(py);
        @(posedge clk);
        model_step();
        #1;
        check_model("model");
    endtask

    task automatic idle(input logic [1:0] b);
        step(b, 1'b0, 1'b0, 1'b0, 5, 5);
    endtask

    task automatic frame(input logic [1:0] b);
        step(b, 1'b0, 1'b0, 1'b1, 0, VDL);
        idle(b);
    endtask

    task automatic wait_play(input int max_frames);
        int n;
        n = 0;
        while (gra_still && n < max_frames) begin
            frame(2'b10);
            n++;
        end
        check("wait_play_timeout", gra_still, 1'b0);
    endtask

    task automatic walk_sync(input int idx);
        int pulses;
        int first;
        int k;
        pulses = 0;
        first  = -1;
        k      = 0;
        for (int y = VDL - 2; y <= VDL + 1; y++) begin
            for (int x = 0; x < 800; x++) begin
                for (int ph = 0; ph < 2; ph++) begin
                    step(2'b00, 1'b0, 1'b0, ph == 0, x, y);
                    if (refr_tick) begin
                        pulses++;
                        if (first < 0) first = k;
                    end
                    k++;
                end
            end
        end
        check($sformatf("sync_pulses_%0d", idx), pulses, 1);
        check($sformatf("sync_pulse_pos_%0d", idx), first, 2 * 1600);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 0,   480, 1'b1};
        vecs[1] = '{1'b0, 0,   480, 1'b0};
        vecs[2] = '{1'b1, 1,   480, 1'b0};
        vecs[3] = '{1'b1, 0,   479, 1'b0};
        vecs[4] = '{1'b1, 0,   481, 1'b0};
        vecs[5] = '{1'b1, 0,   0,   1'b0};
        vecs[6] = '{1'b1, 639, 480, 1'b0};
        vecs[7] = '{1'b1, 0,   480, 1'b1};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_still", gra_still, 1'b1);
        check("rst_text", text_sel, 2'b01);
        check("rst_balls", balls_left, 2'd0);
        check("rst_score", {score_d1, score_d0}, 8'h00);
        check("rst_refr", refr_tick, 1'b0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            step(2'b00, 1'b0, 1'b0, vecs[i].pt, vecs[i].px, vecs[i].py);
            check($sformatf("refr_vec%0d", i), refr_tick, vecs[i].exp_refr);
        end

        for (int f = 0; f < 3; f++) walk_sync(f);

        step(2'b01, 1'b0, 1'b0, 1'b0, 5, 5);
        idle(2'b00);
        check("start_still", gra_still, 1'b0);
        check("start_text", text_sel, 2'b00);
        check("start_balls", balls_left, 2'd3);
        check("start_score", {score_d1, score_d0}, 8'h00);

        repeat (12) step(2'b00, 1'b1, 1'b0, 1'b0, 5, 5);
        check("score_12", {score_d1, score_d0}, 8'h12);
        repeat (87) step(2'b00, 1'b1, 1'b0, 1'b0, 5, 5);
        check("score_99", {score_d1, score_d0}, 8'h99);
        step(2'b00, 1'b1, 1'b0, 1'b0, 5, 5);
        check("score_wrap", {score_d1, score_d0}, 8'h00);

        step(2'b00, 1'b0, 1'b1, 1'b0, 5, 5);
        check("miss1_still", gra_still, 1'b1);
        check("miss1_text", text_sel, 2'b00);
        check("miss1_balls", balls_left, 2'd2);
        repeat (TF - 1) frame(2'b01);
        check("nb_hold_119", gra_still, 1'b1);
        step(2'b01, 1'b0, 1'b0, 1'b1, 0, VDL);
        check("nb_tick120", refr_tick, 1'b1);
        check("nb_tick120_still", gra_still, 1'b1);
        idle(2'b01);
        check("nb_timer_zero_still", gra_still, 1'b1);
        idle(2'b01);
        check("nb_back_play", gra_still, 1'b0);

        step(2'b00, 1'b0, 1'b1, 1'b0, 5, 5);
        check("miss2_balls", balls_left, 2'd1);
        wait_play(TF + 4);
        repeat (5) step(2'b00, 1'b1, 1'b0, 1'b0, 5, 5);
        step(2'b00, 1'b0, 1'b1, 1'b0, 5, 5);
        check("over_text", text_sel, 2'b10);
        check("over_balls", balls_left, 2'd0);
        check("over_still", gra_still, 1'b1);
        repeat (TF) frame(2'b00);
        for (int n = 0; n < 4 && text_sel != 2'b01; n++) idle(2'b00);
        check("newgame_text", text_sel, 2'b01);
        check("newgame_score", {score_d1, score_d0}, 8'h05);

        step(2'b11, 1'b0, 1'b0, 1'b0, 5, 5);
        check("game2_score", {score_d1, score_d0}, 8'h00);
        step(2'b00, 1'b0, 1'b1, 1'b0, 5, 5);
        wait_play(TF + 4);
        step(2'b00, 1'b1, 1'b1, 1'b0, 5, 5);
        check("hm_score", {score_d1, score_d0}, 8'h01);
        check("hm_balls", balls_left, 2'd1);
        check("hm_still", gra_still, 1'b1);
        check("hm_text", text_sel, 2'b00);
        repeat (10) frame(2'b00);
        step(2'b00, 1'b0, 1'b0, 1'b1, 0, VDL);
        #5 reset = 1'b0;
        #1;
        check("async_refr", refr_tick, 1'b0);
        check("async_still", gra_still, 1'b1);
        check("async_text", text_sel, 2'b01);
        check("async_balls", balls_left, 2'd0);
        check("async_score", {score_d1, score_d0}, 8'h00);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 6000; i++) begin
            logic [1:0] b;
            b = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(b, $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
                 1'($urandom), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 799),
                 ($urandom_range(0, 1) == 0) ? VDL : $urandom_range(0, 524));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
